// File: rtl/key_schedule_seq.sv
// Sequential AES key expansion: one 32-bit schedule word per clock into a local
// word store, then 128-bit round keys served through a registered read port.
module key_schedule_seq #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [0:32*Nk-1] key,
    input  logic            key_valid,
    output logic            key_ready,
    output logic            busy,
    output logic            done,
    input  logic            rk_req,
    input  logic [3:0]      rk_idx,
    output logic            rk_valid,
    output logic [0:127]    rk
);

    localparam int NW = 4*Nr + 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            p = p ^ (b[k] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(a, a);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t       state_q;
    logic [5:0]   i_q;
    logic [2:0]   mod_q;
    logic [7:0]   rcon_q;
    logic [31:0]  w_q [NW];
    logic         key_ready_q, busy_q, done_q, rk_valid_q;
    logic [0:127] rk_q;

    logic [5:0]   idx_prev_s, idx_back_s, base_s;
    logic [31:0]  prev_s, back_s, sub_in_s, sub_out_s, temp_s, new_word_s;
    logic         rd_ok_s;
    logic [0:127] rd_key_s;

    // Next schedule word (single shared SubWord) and round-key read mux.
    always_comb begin
        idx_prev_s = i_q - 6'd1;
        idx_back_s = i_q - 6'(Nk);
        prev_s     = w_q[idx_prev_s];
        back_s     = w_q[idx_back_s];
        sub_in_s   = (mod_q == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s;
        sub_out_s  = sub_word(sub_in_s);
        if (mod_q == 3'd0) begin
            temp_s = sub_out_s ^ {rcon_q, 24'h000000};
        end else if (Nk > 6 && mod_q == 3'd4) begin
            temp_s = sub_out_s;
        end else begin
            temp_s = prev_s;
        end
        new_word_s = back_s ^ temp_s;
        rd_ok_s    = (rk_idx <= 4'(Nr));
        base_s     = rd_ok_s ? {rk_idx, 2'b00} : 6'd0;
        rd_key_s   = {w_q[base_s], w_q[base_s + 6'd1], w_q[base_s + 6'd2], w_q[base_s + 6'd3]};
    end

    // Control FSM, word store, and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= 6'd0;
            mod_q       <= 3'd0;
            rcon_q      <= 8'h01;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rk_valid_q  <= 1'b0;
            rk_q        <= 128'h0;
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= 32'h0;
            end
        end else begin
            case (state_q)
                IDLE, READY: begin
                    // The read uses the old store even when a reload captures on this edge.
                    if (state_q == READY && rk_req) begin
                        rk_valid_q <= 1'b1;
                        rk_q       <= rd_ok_s ? rd_key_s : 128'h0;
                    end else begin
                        rk_valid_q <= 1'b0;
                    end
                    if (key_valid) begin
                        for (int k = 0; k < Nk; k++) begin
                            w_q[k] <= key[32*k +: 32];
                        end
                        i_q         <= 6'(Nk);
                        mod_q       <= 3'd0;
                        rcon_q      <= 8'h01;
                        state_q     <= EXPAND;
                        key_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                EXPAND: begin
                    rk_valid_q <= 1'b0;
                    w_q[i_q]   <= new_word_s;
                    i_q        <= i_q + 6'd1;
                    mod_q      <= (mod_q == 3'(Nk-1)) ? 3'd0 : mod_q + 3'd1;
                    if (mod_q == 3'd0) begin
                        rcon_q <= xtime(rcon_q);
                    end else begin
                        rcon_q <= rcon_q;
                    end
                    if (i_q == 6'(NW-1)) begin
                        state_q     <= READY;
                        key_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        state_q <= EXPAND;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    key_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    rk_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign key_ready = key_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rk_valid  = rk_valid_q;
    assign rk        = rk_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: AES-128 instance checked every cycle against a
// FIPS-197 style expansion model, plus an AES-256 instance with directed checks.
module tb_key_schedule_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [127:0] key_a;
    logic         kv_a, rq_a;
    logic [3:0]   ix_a;
    logic         kr_a, bz_a, dn_a, rv_a;
    logic [127:0] rk_a;

    logic [255:0] key_b;
    logic         kv_b, rq_b;
    logic [3:0]   ix_b;
    logic         kr_b, bz_b, dn_b, rv_b;
    logic [127:0] rk_b;

    key_schedule_seq #(.Nk(4), .Nr(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .key(key_a), .key_valid(kv_a), .key_ready(kr_a),
        .busy(bz_a), .done(dn_a), .rk_req(rq_a), .rk_idx(ix_a), .rk_valid(rv_a), .rk(rk_a));

    key_schedule_seq #(.Nk(8), .Nr(14)) dut_b (
        .clk(clk), .rst_n(rst_n), .key(key_b), .key_valid(kv_b), .key_ready(kr_b),
        .busy(bz_b), .done(dn_b), .rk_req(rq_b), .rk_idx(ix_b), .rk_valid(rv_b), .rk(rk_b));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
            sb[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] kb, input int nk, input int nr, output logic [31:0] w [60]);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = kb[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i/nk; j++) rc = gmul(rc, 8'h02);
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] rkey(input logic [31:0] w [60], input int r);
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Model of the AES-128 instance: remaining busy cycles, done flag, read port.
    logic [31:0]  m_w [60];
    int           m_left = 0;
    bit           m_done = 1'b0;
    bit           m_rv   = 1'b0;
    logic [127:0] m_rk   = 128'h0;

    // Advance the model on each edge, then compare every output shortly after.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0; m_rv = 1'b0; m_rk = 128'h0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
            m_rv = 1'b0;
        end else begin
            if (m_done && rq_a) begin
                m_rv = 1'b1;
                m_rk = (ix_a <= 4'd10) ? rkey(m_w, int'(ix_a)) : 128'h0;
            end else begin
                m_rv = 1'b0;
            end
            if (kv_a) begin
                expand({key_a, 128'h0}, 4, 10, m_w);
                m_left = 40;
                m_done = 1'b0;
            end
        end
        #2;
        chk("cyc_busy",  128'(bz_a), 128'(m_left > 0));
        chk("cyc_ready", 128'(kr_a), 128'(m_left == 0));
        chk("cyc_done",  128'(dn_a), 128'(m_done));
        chk("cyc_rkv",   128'(rv_a), 128'(m_rv));
        chk("cyc_rk",    rk_a, m_rk);
    end

    // ---------------- stimulus ----------------
    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KEY_B  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    logic [31:0] w_a1 [60];
    logic [31:0] w_b  [60];
    logic [31:0] w_r  [60];
    logic [127:0] rnd_key;
    int n;

    task automatic wait_a(output int cnt);
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (dn_a) break;
            if (bz_a) cnt++;
            @(negedge clk);
        end
    endtask

    task automatic load_a(input logic [127:0] k);
        @(negedge clk); key_a = k; kv_a = 1'b1;
        @(negedge clk); kv_a = 1'b0;
    endtask

    task automatic rd_a(input logic [3:0] ix, input logic [127:0] exp, input string nm);
        @(negedge clk); rq_a = 1'b1; ix_a = ix;
        @(negedge clk); rq_a = 1'b0;
        chk({nm, "_valid"}, 128'(rv_a), 128'h1);
        chk(nm, rk_a, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        key_a = 128'h0; kv_a = 1'b0; rq_a = 1'b0; ix_a = 4'd0;
        key_b = 256'h0; kv_b = 1'b0; rq_b = 1'b0; ix_b = 4'd0;
        build_sbox();
        expand({KEY_A1, 128'h0}, 4, 10, w_a1);
        expand(KEY_B, 8, 14, w_b);
        chk("model_a1_r1",  rkey(w_a1, 1),  128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_a1_r10", rkey(w_a1, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model_b_r14",  rkey(w_b, 14),  128'h24fc79ccbf0979e9371ac23c6d68de36);
        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(kr_a), 128'h1);
        chk("rst_busy",  128'(bz_a), 128'h0);
        chk("rst_done",  128'(dn_a), 128'h0);
        chk("rst_rk",    rk_a, 128'h0);
        rst_n = 1'b1;

        // AES-256
        @(negedge clk); key_b = KEY_B; kv_b = 1'b1;
        @(negedge clk); kv_b = 1'b0;
        n = 0;
        for (int k = 0; k < 100 && !dn_b; k++) begin
            if (bz_b) n++;
            @(negedge clk);
        end
        chk("b_busy_cycles", 128'(n), 128'd52);
        chk("b_done", 128'(dn_b), 128'h1);
        @(negedge clk); rq_b = 1'b1; ix_b = 4'd14;
        @(negedge clk); ix_b = 4'd0;
        chk("b_r14_valid", 128'(rv_b), 128'h1);
        chk("b_r14", rk_b, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        @(negedge clk); rq_b = 1'b0;
        chk("b_r0", rk_b, KEY_B[255:128]);

        // AES-128 with key_valid held (and a different key) through EXPAND
        @(negedge clk); key_a = KEY_A1; kv_a = 1'b1;
        @(negedge clk); key_a = {$urandom, $urandom, $urandom, $urandom};
        wait_a(n);
        kv_a = 1'b0; key_a = KEY_A1;
        chk("a_busy_cycles_hold", 128'(n), 128'd40);
        rd_a(4'd1,  128'ha0fafe1788542cb123a339392a6c7605, "a_r1");
        rd_a(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "a_r10");
        rd_a(4'd0,  KEY_A1, "a_r0");
        rd_a(4'd11, 128'h0, "a_r11_oob");

        // rk_req during EXPAND
        load_a(KEY_A1);
        rq_a = 1'b1; ix_a = 4'd2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("a_req_in_expand", 128'(rv_a), 128'h0);
        end
        rq_a = 1'b0;
        wait_a(n);

        // Reload in READY with a same-edge read of round 10
        rnd_key = {$urandom, $urandom, $urandom, $urandom};
        expand({rnd_key, 128'h0}, 4, 10, w_r);
        @(negedge clk); key_a = rnd_key; kv_a = 1'b1; rq_a = 1'b1; ix_a = 4'd10;
        @(negedge clk); kv_a = 1'b0; rq_a = 1'b0;
        chk("reload_old_valid", 128'(rv_a), 128'h1);
        chk("reload_old_r10", rk_a, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("reload_done_low", 128'(dn_a), 128'h0);
        chk("reload_busy", 128'(bz_a), 128'h1);
        wait_a(n);
        chk("reload_busy_cycles", 128'(n), 128'd40);
        rd_a(4'd10, rkey(w_r, 10), "reload_new_r10");

        // Burst read of every round of the A.1 schedule
        load_a(KEY_A1);
        wait_a(n);
        @(negedge clk); rq_a = 1'b1; ix_a = 4'd0;
        for (int r = 1; r <= 11; r++) begin
            @(negedge clk);
            chk("burst_valid", 128'(rv_a), 128'h1);
            chk("burst_rk", rk_a, rkey(w_a1, r-1));
            if (r <= 10) ix_a = 4'(r);
            else rq_a = 1'b0;
        end

        // Asynchronous reset at EXPAND cycle 17
        load_a(rnd_key);
        repeat (16) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ready", 128'(kr_a), 128'h1);
        chk("arst_busy",  128'(bz_a), 128'h0);
        chk("arst_done",  128'(dn_a), 128'h0);
        chk("arst_valid", 128'(rv_a), 128'h0);
        chk("arst_rk",    rk_a, 128'h0);
        @(negedge clk); rst_n = 1'b1;
        load_a(KEY_A1);
        wait_a(n);
        chk("arst_busy_cycles", 128'(n), 128'd40);
        rd_a(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "arst_r1");

        // Random traffic checked by the per-cycle model
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            kv_a  = ($urandom_range(0, 19) == 0);
            key_a = {$urandom, $urandom, $urandom, $urandom};
            rq_a  = $urandom_range(0, 1) != 0;
            ix_a  = 4'($urandom_range(0, 15));
        end
        @(negedge clk); kv_a = 1'b0; rq_a = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
